// File: rtl/antares_mult_acc.sv
// Pipelined WIDTH x WIDTH signed/unsigned multiplier with HI/LO accumulator.
// Supports MULT/MADD/MSUB, direct MTHI/MTLO writes, stall and flush.
module antares_mult_acc #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] mult_input_a,
    input  logic [WIDTH-1:0] mult_input_b,
    input  logic             mult_signed_op,
    input  logic [1:0]       mult_op,
    input  logic             mult_enable_op,
    input  logic             mult_stall,
    input  logic             flush,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] mult_hi,
    output logic [WIDTH-1:0] mult_lo,
    output logic             mult_active,
    output logic             mult_ready
);

    localparam int XW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_MADD = 2'b01,
        OP_MSUB = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

`ifndef SYNTHESIS
    generate
        if ((WIDTH < 8) || (WIDTH % 2 != 0) || (STAGES < 2) || (STAGES > 6)) begin : g_bad_param
            $error("antares_mult_acc: illegal WIDTH or STAGES");
        end
    endgenerate
`endif

    // Stage 1: extended operands
    logic            v1_q;
    op_e             op1_q;
    logic [XW-1:0]   a1_q, b1_q;
    logic [XW-1:0]   a_ext, b_ext;

    assign a_ext = {mult_signed_op & mult_input_a[WIDTH-1], mult_input_a};
    assign b_ext = {mult_signed_op & mult_input_b[WIDTH-1], mult_input_b};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1_q <= 1'b0;
        end else if (!mult_stall) begin
            v1_q <= mult_enable_op;
        end
        if (!mult_stall) begin
            op1_q <= op_e'(mult_op);
            a1_q  <= a_ext;
            b1_q  <= b_ext;
        end
    end

    // Sign-extending the (WIDTH+1)-bit operands to 2*WIDTH makes the
    // modulo-2^(2*WIDTH) product exact for every signed/unsigned pair.
    logic [PW-1:0] a1_sx, b1_sx, prod1;
    assign a1_sx = {{(PW-XW){a1_q[XW-1]}}, a1_q};
    assign b1_sx = {{(PW-XW){b1_q[XW-1]}}, b1_q};
    assign prod1 = a1_sx * b1_sx;

    logic          fin_v;
    op_e           fin_op;
    logic [PW-1:0] fin_p;
    logic          mid_any;

    generate
        if (STAGES > 2) begin : g_pipe
            localparam int unsigned N = STAGES - 2;
            logic [N-1:0]  v_q;
            op_e           op_q [N];
            logic [PW-1:0] p_q  [N];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    v_q <= '0;
                end else if (!mult_stall) begin
                    v_q[0] <= v1_q;
                    for (int unsigned i = 1; i < N; i++) begin
                        v_q[i] <= v_q[i-1];
                    end
                end
                if (!mult_stall) begin
                    op_q[0] <= op1_q;
                    p_q[0]  <= prod1;
                    for (int unsigned i = 1; i < N; i++) begin
                        op_q[i] <= op_q[i-1];
                        p_q[i]  <= p_q[i-1];
                    end
                end
            end

            assign fin_v   = v_q[N-1];
            assign fin_op  = op_q[N-1];
            assign fin_p   = p_q[N-1];
            assign mid_any = |v_q;
        end else begin : g_direct
            assign fin_v   = v1_q;
            assign fin_op  = op1_q;
            assign fin_p   = prod1;
            assign mid_any = 1'b0;
        end
    endgenerate

    // Accumulate happens at commit so back-to-back MADD/MSUB chain
    logic             commit;
    logic [PW-1:0]    acc, res;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             ready_q;

    assign commit = fin_v && !mult_stall && !flush;

    always_comb begin
        acc = {hi_q, lo_q};
        res = fin_p;
        case (fin_op)
            OP_MADD: res = acc + fin_p;
            OP_MSUB: res = acc - fin_p;
            default: res = fin_p;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = res[PW-1:WIDTH];
            lo_d = res[WIDTH-1:0];
        end
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ready_q <= commit;
        end
    end

    assign mult_hi     = hi_q;
    assign mult_lo     = lo_q;
    assign mult_ready  = ready_q;
    assign mult_active = v1_q | mid_any;

endmodule
